// File: rtl/alarm_clock_ctrl_if.sv
// Signal bundle between the button/tick front end and the clock/alarm controller.
// Handshake: there is no valid/ready pair. Every input is either a one-clk
// strobe (tick_1hz, btn_*) or a level (alarm_en), sampled on the rising clk
// edge; the controller never back-pressures. Outputs are registered state or
// combinational functions of registered state.
interface alarm_clock_ctrl_if;
    logic        tick_1hz;
    logic        btn_c;
    logic        btn_r;
    logic        btn_l;
    logic        btn_u;
    logic        btn_d;
    logic        alarm_en;
    logic [15:0] disp_bcd;
    logic [4:0]  led;
    logic        ring;
    logic        dp;
    logic [2:0]  state;   // mode FSM state, exposed for observation

    modport master (
        output tick_1hz, btn_c, btn_r, btn_l, btn_u, btn_d, alarm_en,
        input  disp_bcd, led, ring, dp, state
    );

    modport slave (
        input  tick_1hz, btn_c, btn_r, btn_l, btn_u, btn_d, alarm_en,
        output disp_bcd, led, ring, dp, state
    );
endinterface

// File: rtl/alarm_clock_ctrl.sv
// Clock/alarm controller: hh:mm:ss timekeeping, hh:mm alarm, adjust-mode FSM
// and ring generation, all advanced by single-cycle strobes on one clock.
module alarm_clock_ctrl #(
    parameter int HOURS_MOD     = 24,
    parameter int RING_SECS     = 60,
    parameter int ALARM_RST_HR  = 7,
    parameter int ALARM_RST_MIN = 0
) (
    input logic               clk,
    input logic               reset,
    alarm_clock_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        CLOCK  = 3'd0,
        ADJ_CH = 3'd1,
        ADJ_CM = 3'd2,
        ADJ_AH = 3'd3,
        ADJ_AM = 3'd4
    } state_t;

    localparam logic [4:0] HR_MAX  = 5'(HOURS_MOD - 1);
    localparam logic [5:0] MIN_MAX = 6'd59;

    state_t      state, state_next;
    logic [5:0]  sec, sec_next, min, min_next, a_min, a_min_next;
    logic [4:0]  hr, hr_next, a_hr, a_hr_next;
    logic        ring, ring_next, dp, dp_next;
    logic [7:0]  ring_cnt, ring_cnt_next;

    // Only the highest-priority button acts: c > r > l > u > d.
    logic any_btn, act_c, act_r, act_l, act_u, act_d;
    assign any_btn = bus.btn_c | bus.btn_r | bus.btn_l | bus.btn_u | bus.btn_d;
    assign act_c   = bus.btn_c;
    assign act_r   = bus.btn_r & ~bus.btn_c;
    assign act_l   = bus.btn_l & ~bus.btn_r & ~bus.btn_c;
    assign act_u   = bus.btn_u & ~bus.btn_l & ~bus.btn_r & ~bus.btn_c;
    assign act_d   = bus.btn_d & ~bus.btn_u & ~bus.btn_l & ~bus.btn_r & ~bus.btn_c;

    function automatic logic [4:0] step_hr(input logic [4:0] v, input logic up);
        if (up) return (v == HR_MAX) ? 5'd0 : v + 5'd1;
        else    return (v == 5'd0) ? HR_MAX : v - 5'd1;
    endfunction

    function automatic logic [5:0] step_min(input logic [5:0] v, input logic up);
        if (up) return (v == MIN_MAX) ? 6'd0 : v + 6'd1;
        else    return (v == 6'd0) ? MIN_MAX : v - 6'd1;
    endfunction

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        return {4'(v / 6'd10), 4'(v % 6'd10)};
    endfunction

    // State register and all datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= CLOCK;
            sec      <= 6'd0;
            min      <= 6'd0;
            hr       <= 5'd0;
            a_min    <= 6'(ALARM_RST_MIN);
            a_hr     <= 5'(ALARM_RST_HR);
            ring     <= 1'b0;
            ring_cnt <= 8'd0;
            dp       <= 1'b1;
        end else begin
            state    <= state_next;
            sec      <= sec_next;
            min      <= min_next;
            hr       <= hr_next;
            a_min    <= a_min_next;
            a_hr     <= a_hr_next;
            ring     <= ring_next;
            ring_cnt <= ring_cnt_next;
            dp       <= dp_next;
        end
    end

    // Next-state, timekeeping, adjust and ring logic.
    always_comb begin
        state_next    = state;
        sec_next      = sec;
        min_next      = min;
        hr_next       = hr;
        a_min_next    = a_min;
        a_hr_next     = a_hr;
        ring_next     = ring;
        ring_cnt_next = ring_cnt;
        dp_next       = dp;

        case (state)
            CLOCK: begin
                if (bus.tick_1hz) begin
                    dp_next = ~dp;
                    if (sec == MIN_MAX) begin
                        sec_next = 6'd0;
                        if (min == MIN_MAX) begin
                            min_next = 6'd0;
                            hr_next  = step_hr(hr, 1'b1);
                        end else begin
                            min_next = min + 6'd1;
                        end
                    end else begin
                        sec_next = sec + 6'd1;
                    end
                end
                // While ringing, a button only silences the alarm.
                if (ring) begin
                    if (any_btn || !bus.alarm_en) begin
                        ring_next = 1'b0;
                    end else if (bus.tick_1hz) begin
                        ring_cnt_next = ring_cnt - 8'd1;
                        if (ring_cnt == 8'd1) ring_next = 1'b0;
                    end
                end else if (act_c) begin
                    state_next = ADJ_CM;
                end
                // A fresh match overrides any clear in the same cycle.
                if (bus.tick_1hz && bus.alarm_en && sec_next == 6'd0 &&
                    min_next == a_min && hr_next == a_hr) begin
                    ring_next     = 1'b1;
                    ring_cnt_next = 8'(RING_SECS);
                end
            end
            ADJ_CH, ADJ_CM, ADJ_AH, ADJ_AM: begin
                if (act_c) begin
                    state_next = CLOCK;
                end else if (act_r) begin
                    case (state)
                        ADJ_CH:  state_next = ADJ_CM;
                        ADJ_CM:  state_next = ADJ_AH;
                        ADJ_AH:  state_next = ADJ_AM;
                        default: state_next = ADJ_CH;
                    endcase
                end else if (act_l) begin
                    case (state)
                        ADJ_CH:  state_next = ADJ_AM;
                        ADJ_CM:  state_next = ADJ_CH;
                        ADJ_AH:  state_next = ADJ_CM;
                        default: state_next = ADJ_AH;
                    endcase
                end else if (act_u || act_d) begin
                    case (state)
                        ADJ_CH: hr_next = step_hr(hr, act_u);
                        ADJ_CM: begin
                            min_next = step_min(min, act_u);
                            sec_next = 6'd0;
                        end
                        ADJ_AH:  a_hr_next  = step_hr(a_hr, act_u);
                        default: a_min_next = step_min(a_min, act_u);
                    endcase
                end
            end
            default: state_next = CLOCK;
        endcase

        // Ring only exists in CLOCK; the blink dot is held off while adjusting.
        if (state_next != CLOCK) begin
            ring_next     = 1'b0;
            ring_cnt_next = 8'd0;
            dp_next       = 1'b1;
        end
    end

    // Display source select and mode LEDs.
    logic        show_alarm;
    logic [4:0]  shown_hr;
    logic [5:0]  shown_min;
    assign show_alarm = (state == ADJ_AH) || (state == ADJ_AM);
    assign shown_hr   = show_alarm ? a_hr : hr;
    assign shown_min  = show_alarm ? a_min : min;

    // Mode indicator decode.
    always_comb begin
        bus.led = 5'b00000;
        case (state)
            ADJ_CH:  bus.led = 5'b00101;
            ADJ_CM:  bus.led = 5'b00011;
            ADJ_AH:  bus.led = 5'b10001;
            ADJ_AM:  bus.led = 5'b01001;
            default: bus.led = 5'b00000;
        endcase
    end

    assign bus.disp_bcd = {to_bcd({1'b0, shown_hr}), to_bcd(shown_min)};
    assign bus.ring     = ring;
    assign bus.dp       = dp;
    assign bus.state    = state;
endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Bench for alarm_clock_ctrl: a 24-hour and a 12-hour instance share stimulus
// and are each compared against a seconds/minutes-of-day reference model.
module tb_alarm_clock_ctrl;
    localparam int RING_SECS = 60;
    localparam logic [4:0] B_N = 5'b00000;
    localparam logic [4:0] B_C = 5'b10000;
    localparam logic [4:0] B_R = 5'b01000;
    localparam logic [4:0] B_L = 5'b00100;
    localparam logic [4:0] B_U = 5'b00010;
    localparam logic [4:0] B_D = 5'b00001;

    // Clock and reset.
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       alarm_en = 1'b0;
    logic [4:0] btn = 5'b00000;   // {c, r, l, u, d}

    alarm_clock_ctrl_if bus0 ();
    alarm_clock_ctrl_if bus1 ();
    assign bus0.tick_1hz = tick;     assign bus1.tick_1hz = tick;
    assign bus0.btn_c    = btn[4];   assign bus1.btn_c    = btn[4];
    assign bus0.btn_r    = btn[3];   assign bus1.btn_r    = btn[3];
    assign bus0.btn_l    = btn[2];   assign bus1.btn_l    = btn[2];
    assign bus0.btn_u    = btn[1];   assign bus1.btn_u    = btn[1];
    assign bus0.btn_d    = btn[0];   assign bus1.btn_d    = btn[0];
    assign bus0.alarm_en = alarm_en; assign bus1.alarm_en = alarm_en;

    alarm_clock_ctrl #(.HOURS_MOD(24), .RING_SECS(RING_SECS)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0));
    alarm_clock_ctrl #(.HOURS_MOD(12), .RING_SECS(RING_SECS)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1));

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: time as seconds of day, alarm as minute of day,
    // mode 0 = CLOCK, 1..4 = CH, CM, AH, AM in ring order.
    int   hmod[2] = '{24, 12};
    int   m_t[2], m_am[2], m_md[2], m_left[2];
    bit   m_ring[2], m_dp[2];
    logic [4:0] led_tab[5] = '{5'b00000, 5'b00101, 5'b00011, 5'b10001, 5'b01001};

    task automatic cmp(string tag, logic [15:0] got, logic [15:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] bcd_of(int mins_of_day);
        int hh, mm;
        hh = mins_of_day / 60;
        mm = mins_of_day % 60;
        return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_t[i] = 0; m_am[i] = 7 * 60; m_md[i] = 0; m_left[i] = 0;
            m_ring[i] = 1'b0; m_dp[i] = 1'b1;
        end
    endtask

    task automatic model_step(int i);
        bit was_ring;
        int delta, h, mm, ah;
        was_ring = m_ring[i];
        if (m_md[i] == 0) begin
            if (tick) begin
                m_t[i] = (m_t[i] + 1) % (hmod[i] * 3600);
                m_dp[i] = !m_dp[i];
            end
            if (was_ring) begin
                if (btn != 0 || !alarm_en) m_ring[i] = 1'b0;
                else if (tick) begin
                    m_left[i]--;
                    if (m_left[i] == 0) m_ring[i] = 1'b0;
                end
            end else if (btn[4]) m_md[i] = 2;
            if (tick && alarm_en && m_t[i] % 60 == 0 && m_t[i] / 60 == m_am[i]) begin
                m_ring[i] = 1'b1;
                m_left[i] = RING_SECS;
            end
        end else begin
            if (btn[4]) m_md[i] = 0;
            else if (btn[3]) m_md[i] = m_md[i] % 4 + 1;
            else if (btn[2]) m_md[i] = (m_md[i] + 2) % 4 + 1;
            else if (btn[1] || btn[0]) begin
                delta = btn[1] ? 1 : -1;
                case (m_md[i])
                    1: begin
                        h = (m_t[i] / 3600 + delta + hmod[i]) % hmod[i];
                        m_t[i] = h * 3600 + m_t[i] % 3600;
                    end
                    2: begin
                        mm = ((m_t[i] / 60) % 60 + delta + 60) % 60;
                        m_t[i] = (m_t[i] / 3600) * 3600 + mm * 60;
                    end
                    3: begin
                        ah = (m_am[i] / 60 + delta + hmod[i]) % hmod[i];
                        m_am[i] = ah * 60 + m_am[i] % 60;
                    end
                    default: m_am[i] = (m_am[i] / 60) * 60 + (m_am[i] % 60 + delta + 60) % 60;
                endcase
            end
        end
        if (m_md[i] != 0) begin
            m_ring[i] = 1'b0;
            m_dp[i] = 1'b1;
        end
    endtask

    // Scoreboard: every observable output of both instances against the model.
    task automatic check_model(string tag);
        logic [15:0] disp;
        logic [4:0]  led;
        logic        rg, d;
        int          shown;
        for (int i = 0; i < 2; i++) begin
            disp = (i == 0) ? bus0.disp_bcd : bus1.disp_bcd;
            led  = (i == 0) ? bus0.led : bus1.led;
            rg   = (i == 0) ? bus0.ring : bus1.ring;
            d    = (i == 0) ? bus0.dp : bus1.dp;
            shown = (m_md[i] >= 3) ? m_am[i] : m_t[i] / 60;
            cmp($sformatf("%s_i%0d_disp", tag, i), disp, bcd_of(shown));
            cmp($sformatf("%s_i%0d_led", tag, i), {11'd0, led}, {11'd0, led_tab[m_md[i]]});
            cmp($sformatf("%s_i%0d_ring", tag, i), {15'd0, rg}, {15'd0, m_ring[i]});
            cmp($sformatf("%s_i%0d_dp", tag, i), {15'd0, d}, {15'd0, m_dp[i]});
        end
    endtask

    // Directed checks against hand-derived constants.
    task automatic check_const(string tag, logic [15:0] disp, logic [4:0] led, logic rg);
        cmp({tag, "_i0_disp"}, bus0.disp_bcd, disp);
        cmp({tag, "_i1_disp"}, bus1.disp_bcd, disp);
        cmp({tag, "_i0_led"}, {11'd0, bus0.led}, {11'd0, led});
        cmp({tag, "_i1_led"}, {11'd0, bus1.led}, {11'd0, led});
        cmp({tag, "_i0_ring"}, {15'd0, bus0.ring}, {15'd0, rg});
        cmp({tag, "_i1_ring"}, {15'd0, bus1.ring}, {15'd0, rg});
    endtask

    // Driver: one clock of stimulus, model update at the edge, check after it.
    task automatic step(bit tk, logic [4:0] b, string tag);
        @(negedge clk);
        tick = tk;
        btn = b;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        tick = 1'b0;
        btn = B_N;
        check_model(tag);
    endtask

    task automatic ticks(int n);
        repeat (n) step(1'b1, B_N, "tick");
    endtask

    // From CLOCK: set time to hh:mm:00 (hh < 12 keeps both instances aligned).
    task automatic goto_time(int hh, int mm);
        int ch, cm;
        step(1'b0, B_C, "goto");
        step(1'b0, B_L, "goto");
        ch = m_t[0] / 3600;
        if (hh >= ch) repeat (hh - ch) step(1'b0, B_U, "goto_h");
        else          repeat (ch - hh) step(1'b0, B_D, "goto_h");
        step(1'b0, B_R, "goto");
        cm = (m_t[0] / 60) % 60;
        if (mm == cm) begin
            step(1'b0, B_U, "goto_m");
            step(1'b0, B_D, "goto_m");
        end else if (mm > cm) repeat (mm - cm) step(1'b0, B_U, "goto_m");
        else                  repeat (cm - mm) step(1'b0, B_D, "goto_m");
        step(1'b0, B_C, "goto");
    endtask

    initial begin
        // Reset state.
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        check_const("reset", 16'h0000, 5'b00000, 1'b0);
        reset = 1'b0;

        // Rollover: 23:59:59 (11:59:59 on the 12-hour unit) plus one tick.
        step(1'b0, B_C, "roll");
        step(1'b0, B_L, "roll");
        step(1'b0, B_D, "roll");
        step(1'b0, B_R, "roll");
        step(1'b0, B_D, "roll");
        step(1'b0, B_C, "roll");
        ticks(59);
        step(1'b1, B_N, "roll");
        check_const("rollover", 16'h0000, 5'b00000, 1'b0);

        // Adjust wrap on the alarm hour.
        step(1'b0, B_C, "wrap");
        step(1'b0, B_R, "wrap");
        step(1'b0, B_D, "wrap");
        check_const("adj_wrap_dn", 16'h0600, 5'b10001, 1'b0);
        repeat (18) step(1'b0, B_U, "wrap");
        check_const("adj_wrap_up", 16'h0000, 5'b10001, 1'b0);
        repeat (7) step(1'b0, B_U, "wrap");
        step(1'b0, B_C, "wrap");

        // Field isolation: minute wrap does not carry into the hour.
        step(1'b0, B_C, "iso");
        step(1'b0, B_L, "iso");
        repeat (10) step(1'b0, B_U, "iso");
        step(1'b0, B_R, "iso");
        step(1'b0, B_D, "iso");
        check_const("iso_1059", 16'h1059, 5'b00011, 1'b0);
        step(1'b0, B_U, "iso");
        check_const("iso_1000", 16'h1000, 5'b00011, 1'b0);

        // Priority: c beats u.
        step(1'b0, B_C | B_U, "prio");
        check_const("prio", 16'h1000, 5'b00000, 1'b0);

        // Alarm rings at 07:00 and times out after RING_SECS ticks.
        goto_time(6, 59);
        alarm_en = 1'b1;
        ticks(59);
        step(1'b1, B_N, "alarm");
        check_const("ring_on", 16'h0700, 5'b00000, 1'b1);
        ticks(RING_SECS - 1);
        check_const("ring_hold", 16'h0700, 5'b00000, 1'b1);
        step(1'b1, B_N, "alarm");
        check_const("ring_timeout", 16'h0701, 5'b00000, 1'b0);

        // Button while ringing only silences.
        goto_time(6, 59);
        ticks(59);
        step(1'b1, B_N, "alarm2");
        check_const("ring_on2", 16'h0700, 5'b00000, 1'b1);
        step(1'b0, B_U, "alarm2");
        check_const("ring_btn", 16'h0700, 5'b00000, 1'b0);

        // Asynchronous reset mid-adjust.
        step(1'b0, B_C, "ares");
        step(1'b0, B_R, "ares");
        step(1'b0, B_R, "ares");
        step(1'b0, B_U, "ares");
        check_const("ares_pre", 16'h0701, 5'b01001, 1'b0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_model("ares");
        check_const("ares_now", 16'h0000, 5'b00000, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, B_C, "ares");
        step(1'b0, B_R, "ares");
        check_const("ares_alarm", 16'h0700, 5'b10001, 1'b0);
        step(1'b0, B_C, "ares");

        // Randomized phase against the model.
        for (int n = 0; n < 600; n++) begin
            logic [4:0] b;
            b = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : B_N;
            if ($urandom_range(0, 15) == 0) alarm_en = ~alarm_en;
            step(1'($urandom_range(0, 1)), b, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/alarm_clock_ctrl.md
# alarm_clock_ctrl

Parametrised clock/alarm controller: keeps hh:mm:ss time and an hh:mm alarm, runs the mode FSM that adjusts either, and raises a ring output on alarm match. It sits between the pushbutton detectors and the 7-segment multiplexer. All logic runs on one clock and is advanced by single-cycle enable strobes instead of derived clocks.

## Interface
- HOURS_MOD, 24, hour modulus; hours count 0..HOURS_MOD-1; legal values 12..24
- RING_SECS, 60, ring auto-timeout in tick_1hz pulses; legal values 1..255
- ALARM_RST_HR, 7, alarm hour after reset; must be < HOURS_MOD
- ALARM_RST_MIN, 0, alarm minute after reset; legal values 0..59

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- tick_1hz  in  1  one-clk pulse per second
- btn_c, btn_r, btn_l, btn_u, btn_d  in  1 each  debounced one-clk button pulses
- alarm_en  in  1  alarm arm switch (level)
- disp_bcd  out  16  {hr_tens, hr_ones, min_tens, min_ones} BCD of the displayed field set
- led  out  5  mode indicators
- ring  out  1  alarm sounding
- dp  out  1  seconds blink, active-low

## Operation
- Internal registers are binary: sec 0..59, min 0..59, hr 0..HOURS_MOD-1, a_min, a_hr. disp_bcd is a combinational binary-to-BCD conversion of registered values.
- FSM states and led values:
  - CLOCK: led=00000
  - ADJ_CH (clock hour): led=00101
  - ADJ_CM (clock minute): led=00011
  - ADJ_AH (alarm hour): led=10001
  - ADJ_AM (alarm minute): led=01001
- disp_bcd shows the alarm in ADJ_AH/ADJ_AM and the time in all other states.
- Button priority when several pulse in the same cycle: c > r > l > u > d. Only the highest-priority button acts.
- Ring consumption: while ring=1, any button pulse clears ring and has no other effect.
- CLOCK:
  - btn_c goes to ADJ_CM.
  - tick_1hz advances sec. Carry rolls 59 to 0 into min, min 59 to 0 into hr, hr HOURS_MOD-1 to 0.
  - u, d, r and l are ignored.
- ADJ_* states:
  - Time is frozen; tick_1hz is ignored for timekeeping.
  - btn_c returns to CLOCK.
  - btn_r steps the ring order CH→CM→AH→AM→CH.
  - btn_l steps the same ring in reverse.
  - btn_u increments the selected field modulo its range, with no carry into any other field.
  - btn_d decrements the selected field modulo its range (0 goes to max).
  - Any u/d in ADJ_CM also clears sec to 0.
- Alarm:
  - In CLOCK, a tick that produces sec=0 with min==a_min, hr==a_hr and alarm_en=1 sets ring.
  - ring clears on any button pulse, on alarm_en=0, or after RING_SECS further ticks.
  - A ring counter (8 bit) is loaded to RING_SECS on set and decrements per tick.
  - Leaving CLOCK clears ring.
- dp: in CLOCK it toggles on every tick (reset value 1). In ADJ_* it is held at 1.

## Timing
- Reset values:
  - time 00:00:00
  - alarm ALARM_RST_HR:ALARM_RST_MIN
  - state CLOCK, led=00000, ring=0, dp=1, ring counter 0
- All state updates take effect on the clk edge that samples the pulse. Outputs change 1 cycle after the input pulse.
- tick_1hz and a button in the same cycle in CLOCK: the tick advances time and the button is processed. If btn_c, the next state is ADJ_CM with the ticked time frozen.
- The alarm compare uses the post-tick values. ring rises in the same cycle that disp_bcd shows the matching minute.
- A ring clear and a new match in the same cycle: the match wins, and ring stays 1 with the counter reloaded.
- reset mid-adjust returns immediately to CLOCK with the reset values above. No partial edit survives.
- Inputs are synchronous to clk. Pulses longer than one cycle act once per cycle asserted, and the bench must not rely on this.

## Test plan
- Rollover: reset, force time 23:59:59 via adjust, apply one tick → disp_bcd=0x0000, sec=0. With HOURS_MOD=12, 11:59:59 + tick → 00:00.
- Adjust wrap: btn_c, btn_r to ADJ_AH, 1 btn_d → alarm 06:00, disp_bcd=0x0600, led=10001. Then btn_u×18 → 00:00.
- Field isolation: in ADJ_CM at 10:59, btn_u → 10:00 (hr unchanged), sec=0.
- Alarm: alarm 07:00, alarm_en=1, time 06:59:59, one tick → ring=1 next cycle. 60 ticks later ring=0. Repeat: btn_u while ringing → ring=0 with time unchanged.
- Priority: btn_c and btn_u in the same cycle in ADJ_CM → state CLOCK, minute unchanged.
- Async reset: assert reset between clk edges while in ADJ_AM → ring=0, led=00000, alarm 07:00 immediately, without waiting for an edge.
